// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux N:1 registered multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the channel after the last winner.
// The pointer moves only when Advance is asserted by the owner of the grant.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [N-1:0]    Req,
    input  logic            Advance,
    output logic [N-1:0]    Gnt,
    output logic [SELW-1:0] Gnt_Idx
);

    logic [SELW-1:0] last;

    always_comb begin
        logic            found;
        logic [SELW-1:0] cand;
        Gnt     = '0;
        Gnt_Idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SELW'((int'(last) + k) % N);
            if (!found && Req[cand]) begin
                found       = 1'b1;
                Gnt[cand]   = 1'b1;
                Gnt_Idx     = cand;
            end
        end
    end

    // Reset to N-1 so that channel 0 is searched first.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last <= SELW'(N - 1);
        end else if (Advance) begin
            last <= Gnt_Idx;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream multiplexer with a one-entry registered output,
// fixed or round-robin selection. STREAM_MUX_COUNT_EN adds per-channel transfer counters.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 2,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N*WIDTH-1:0] In_Data,
    input  logic [N-1:0]       In_Valid,
    output logic [N-1:0]       In_Ready,
    input  logic [SELW-1:0]    Sel,
    input  logic               Mode,
    output logic [WIDTH-1:0]   Out_Data,
    output logic [SELW-1:0]    Out_Chan,
    output logic               Out_Valid,
    input  logic               Out_Ready
`ifdef STREAM_MUX_COUNT_EN
    ,
    input  logic               Count_Clr,
    output logic [N*COUNT_W-1:0] Xfer_Count
`endif
);

    mode_e           mode;
    logic [N-1:0]    gnt_fix;
    logic [SELW-1:0] idx_fix;
    logic [N-1:0]    gnt_rr;
    logic [SELW-1:0] idx_rr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic            load;
    logic            xfer;

    assign mode = mode_e'(Mode);

    // A select beyond the last channel never grants.
    always_comb begin
        gnt_fix = '0;
        idx_fix = '0;
        if (N == 1) begin
            gnt_fix[0] = In_Valid[0];
        end else if (int'(Sel) < N) begin
            gnt_fix[Sel] = In_Valid[Sel];
            idx_fix      = Sel;
        end
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req     (In_Valid),
        .Advance (xfer && (mode == MODE_RR)),
        .Gnt     (gnt_rr),
        .Gnt_Idx (idx_rr)
    );

    assign grant     = (mode == MODE_RR) ? gnt_rr : gnt_fix;
    assign grant_idx = (mode == MODE_RR) ? idx_rr : idx_fix;
    assign load      = !Out_Valid || Out_Ready;
    assign In_Ready  = load ? grant : '0;
    assign xfer      = load && (|grant);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Chan  <= '0;
        end else if (load) begin
            if (xfer) begin
                Out_Valid <= 1'b1;
                Out_Data  <= grant_data;
                Out_Chan  <= grant_idx;
            end else begin
                Out_Valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_COUNT_EN
    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic [COUNT_W-1:0] cnt;

        // Clear takes priority over a same-cycle transfer.
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                cnt <= '0;
            end else if (Count_Clr) begin
                cnt <= '0;
            end else if (In_Valid[i] && In_Ready[i]) begin
                cnt <= sat_inc(cnt);
            end
        end

        assign Xfer_Count[i*COUNT_W +: COUNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed and randomised bench for stream_mux (N=4, WIDTH=8) plus an N=3 instance
// for the out-of-range select case; expected words flow through a scoreboard queue.
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic        count_clr;
    logic [63:0] xfer_count;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;
    logic        count_clr3;
    logic [47:0] xfer_count3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [9:0] sb[$];
    logic       m_valid;
    logic [1:0] m_last;
    int         m_cnt[4];

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(8), .N(4)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .In_Data    (in_data),
        .In_Valid   (in_valid),
        .In_Ready   (in_ready),
        .Sel        (sel),
        .Mode       (mode),
        .Out_Data   (out_data),
        .Out_Chan   (out_chan),
        .Out_Valid  (out_valid),
        .Out_Ready  (out_ready)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .Count_Clr  (count_clr),
        .Xfer_Count (xfer_count)
`endif
    );

    stream_mux #(.WIDTH(8), .N(3)) dut3 (
        .Clk        (clk),
        .Rst        (rst),
        .In_Data    (in_data3),
        .In_Valid   (in_valid3),
        .In_Ready   (in_ready3),
        .Sel        (sel3),
        .Mode       (mode3),
        .Out_Data   (out_data3),
        .Out_Chan   (out_chan3),
        .Out_Valid  (out_valid3),
        .Out_Ready  (out_ready3)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .Count_Clr  (count_clr3),
        .Xfer_Count (xfer_count3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] model_grant(input logic md, input logic [1:0] s,
                                               input logic [3:0] v, input logic [1:0] last);
        logic [3:0] g;
        logic [1:0] c;
        g = '0;
        if (!md) begin
            if (v[s]) g[s] = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c = 2'((int'(last) + k) % 4);
                if (g == 4'b0 && v[c]) g[c] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_valid = 1'b0;
        m_last  = 2'd3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // One clock: check In_Ready against the model, predict the transfer, check outputs.
    task automatic cycle();
        logic [3:0] g;
        logic [3:0] exp_rdy;
        logic       load;
        int         idx;
        #1;
        load = !m_valid || out_ready;
        if (m_valid && out_ready) sb.delete(0);
        g = model_grant(mode, sel, in_valid, m_last);
        exp_rdy = load ? g : 4'b0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy != 4'b0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) idx = i;
            sb.push_back({in_data[idx*8 +: 8], 2'(idx)});
            m_valid = 1'b1;
            if (mode) m_last = 2'(idx);
            if (m_cnt[idx] < 65535) m_cnt[idx]++;
        end else if (load) begin
            m_valid = 1'b0;
        end
        if (count_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid && sb.size() > 0) begin
            check("out_data", 64'(out_data), 64'(sb[0][9:2]));
            check("out_chan", 64'(out_chan), 64'(sb[0][1:0]));
        end
    endtask

    task automatic check_counts();
`ifdef STREAM_MUX_COUNT_EN
        for (int i = 0; i < 4; i++) begin
            check($sformatf("xfer_count%0d", i), 64'(xfer_count[i*16 +: 16]), 64'(m_cnt[i]));
        end
`endif
    endtask

    initial begin
        logic [1:0] seq_all[5];
        logic [1:0] seq_alt[4];
        seq_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_alt = '{2'd1, 2'd3, 2'd1, 2'd3};

        rst = 1'b1;
        in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0; count_clr = 1'b0;
        in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b0; count_clr3 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fixed select basic
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h33A5_2211; out_ready = 1'b1;
        #1;
        check("fixed_in_ready", 64'(in_ready), 64'h4);
        cycle();
        check("fixed_out_data", 64'(out_data), 64'hA5);
        check("fixed_out_chan", 64'(out_chan), 64'd2);
        in_valid = 4'b0000;
        cycle();

        // Back-pressure with a loaded word
        in_valid = 4'b0100;
        cycle();
        out_ready = 1'b0; in_valid = 4'b1111;
        repeat (5) cycle();
        check("bp_hold_data", 64'(out_data), 64'hA5);
        out_ready = 1'b1; in_data = 32'h4477_6655;
        cycle();
        check("bp_release_data", 64'(out_data), 64'h77);

        // Round-robin fairness
        mode = 1'b1; in_valid = 4'b1111; in_data = 32'hD4C3_B2A1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("rr_all_%0d", i), 64'(out_chan), 64'(seq_all[i]));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("rr_alt_%0d", i), 64'(out_chan), 64'(seq_alt[i]));
        end

        // Mode 0 transfers must not move the round-robin pointer
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        repeat (2) cycle();
        mode = 1'b1;
        cycle();
        check("rr_after_fixed", 64'(out_chan), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check_counts();

        // Async reset mid-stream
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        cycle();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; in_data = 32'h8877_6655;
        cycle();
        check("post_reset_chan", 64'(out_chan), 64'd0);
        check_counts();

        // N=3 instance: select 3 is out of range
        mode3 = 1'b0; out_ready3 = 1'b1; in_data3 = 24'h66_55_44; in_valid3 = 3'b111; sel3 = 2'd1;
        #1;
        check("n3_in_ready_sel1", 64'(in_ready3), 64'h2);
        @(posedge clk);
        #1;
        check("n3_out_valid", 64'(out_valid3), 64'd1);
        check("n3_out_data", 64'(out_data3), 64'h55);
        sel3 = 2'd3;
        #1;
        check("n3_in_ready_sel3", 64'(in_ready3), 64'h0);
        @(posedge clk);
        #1;
        check("n3_drain_valid", 64'(out_valid3), 64'd0);
        check("n3_hold_data", 64'(out_data3), 64'h55);
        check("n3_hold_chan", 64'(out_chan3), 64'd1);
        sel3 = 2'd2;
        #1;
        check("n3_in_ready_sel2", 64'(in_ready3), 64'h4);
        in_valid3 = 3'b000;

`ifdef STREAM_MUX_COUNT_EN
        // Saturation: 70000 back-to-back transfers on channel 1
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_5A00; out_ready = 1'b1;
        cycle();
        repeat (70000) @(posedge clk);
        #1;
        m_cnt[1] = 65535;
        sb.delete();
        sb.push_back({8'h5A, 2'd1});
        check_counts();
        count_clr = 1'b1;
        cycle();
        count_clr = 1'b0;
        check_counts();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
